// File: rtl/mini_machine.sv
// Timer-driven accumulator micro-system with an 8-bit output port and a seven-segment driver.
// Build option: define MINI_MACHINE_SATURATE_EN to clamp the accumulator at all-ones instead of wrapping.
module mini_machine #(
    parameter int unsigned TIMER_PRESET = 16
) (
    input  logic        clk,
    input  logic        mips_rst,
    input  logic        timer_rst,
    input  logic        segment_rst,
    input  logic [31:0] DIn,
    output logic [7:0]  DOut,
    output logic [7:0]  segment
);

    localparam logic [15:0] TimerReload = 16'(TIMER_PRESET - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StAdd} state_e;

    logic [15:0] cnt_q;
    logic        irq_q;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] din_q, din_d;
    logic        pend_q, pend_d;
    logic [7:0]  dout_q, dout_d;
    logic [31:0] acc_next;

    logic [6:0]  seg_hex;
    logic        seg_dp;

    // Timer: one-cycle irq pulse every TIMER_PRESET edges.
    always_ff @(posedge clk or posedge timer_rst) begin
        if (timer_rst) begin
            cnt_q <= TimerReload;
            irq_q <= 1'b0;
        end else if (cnt_q == 16'd0) begin
            cnt_q <= TimerReload;
            irq_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q - 16'd1;
            irq_q <= 1'b0;
        end
    end

`ifdef MINI_MACHINE_SATURATE_EN
    logic [32:0] acc_sum;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, din_q};
    assign acc_next = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
`else
    assign acc_next = acc_q + din_q;
`endif

    always_ff @(posedge clk or posedge mips_rst) begin
        if (mips_rst) begin
            state_q <= StIdle;
            acc_q   <= 32'd0;
            din_q   <= 32'd0;
            pend_q  <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            din_q   <= din_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        din_d   = din_q;
        pend_d  = pend_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle: begin
                if (irq_q || pend_q) begin
                    din_d   = DIn;
                    pend_d  = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                acc_d   = acc_next;
                state_d = StAdd;
                if (irq_q) pend_d = 1'b1;
            end
            StAdd: begin
                dout_d  = acc_q[7:0];
                state_d = StIdle;
                // An irq on the return edge is kept and serviced from IDLE next edge.
                if (irq_q) pend_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign DOut = dout_q;

    always_comb begin
        seg_hex = 7'h7F;
        unique case (dout_q[3:0])
            4'h0: seg_hex = 7'h40;
            4'h1: seg_hex = 7'h79;
            4'h2: seg_hex = 7'h24;
            4'h3: seg_hex = 7'h30;
            4'h4: seg_hex = 7'h19;
            4'h5: seg_hex = 7'h12;
            4'h6: seg_hex = 7'h02;
            4'h7: seg_hex = 7'h78;
            4'h8: seg_hex = 7'h00;
            4'h9: seg_hex = 7'h10;
            4'hA: seg_hex = 7'h08;
            4'hB: seg_hex = 7'h03;
            4'hC: seg_hex = 7'h46;
            4'hD: seg_hex = 7'h21;
            4'hE: seg_hex = 7'h06;
            4'hF: seg_hex = 7'h0E;
        endcase
    end

    // Decimal point lit (low) when the high nibble is non-zero.
    assign seg_dp = (dout_q[7:4] == 4'h0);

    always_ff @(posedge clk or posedge segment_rst) begin
        if (segment_rst) begin
            segment <= 8'hFF;
        end else begin
            segment <= {seg_dp, seg_hex};
        end
    end

endmodule

// File: tb/tb_mini_machine.sv
// Scoreboard bench for mini_machine: expected DOut values and edge numbers are queued as stimulus
// is applied and matched whenever DOut changes; segment is checked one edge later.
module tb_mini_machine;

    logic        clk = 1'b0;
    logic        mips_rst = 1'b1;
    logic        timer_rst = 1'b1;
    logic        segment_rst = 1'b1;
    logic [31:0] din = 32'd0;
    logic [7:0]  dout;
    logic [7:0]  seg;

    logic        rst4 = 1'b1;
    logic [31:0] din4 = 32'd0;
    logic [7:0]  dout4;
    logic [7:0]  seg4;

    always #5 clk = ~clk;

    mini_machine #(.TIMER_PRESET(16)) dut (
        .clk         (clk),
        .mips_rst    (mips_rst),
        .timer_rst   (timer_rst),
        .segment_rst (segment_rst),
        .DIn         (din),
        .DOut        (dout),
        .segment     (seg)
    );

    mini_machine #(.TIMER_PRESET(4)) dut4 (
        .clk         (clk),
        .mips_rst    (rst4),
        .timer_rst   (rst4),
        .segment_rst (rst4),
        .DIn         (din4),
        .DOut        (dout4),
        .segment     (seg4)
    );

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         sel = 1'b0;
    logic [7:0] prev_dout = 8'h00;
    logic [7:0] seg_exp = 8'hFF;
    bit         seg_pending = 1'b0;

    function automatic logic [7:0] seg_of(input logic [7:0] v);
        logic [6:0] h;
        case (v[3:0])
            4'h0: h = 7'h40;  4'h1: h = 7'h79;  4'h2: h = 7'h24;  4'h3: h = 7'h30;
            4'h4: h = 7'h19;  4'h5: h = 7'h12;  4'h6: h = 7'h02;  4'h7: h = 7'h78;
            4'h8: h = 7'h00;  4'h9: h = 7'h10;  4'hA: h = 7'h08;  4'hB: h = 7'h03;
            4'hC: h = 7'h46;  4'hD: h = 7'h21;  4'hE: h = 7'h06;  default: h = 7'h0E;
        endcase
        return {(v[7:4] == 4'h0), h};
    endfunction

    task automatic push(input logic [7:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Advance n edges; on every DOut change pop the scoreboard and compare value and edge number.
    task automatic run_sb(input int n);
        exp_t       e;
        logic [7:0] obs_d;
        logic [7:0] obs_s;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            obs_d = sel ? dout4 : dout;
            obs_s = sel ? seg4 : seg;
            if (seg_pending) begin
                checks++;
                if (obs_s !== seg_exp) begin
                    errors++;
                    $display("FAIL segment cyc=%0d got=%h exp=%h", cyc, obs_s, seg_exp);
                end
                seg_pending = 1'b0;
            end
            if (obs_d !== prev_dout) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dout_unexpected cyc=%0d got=%h exp=%h", cyc, obs_d, prev_dout);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (obs_d !== e.val) begin
                        errors++;
                        $display("FAIL dout_value cyc=%0d got=%h exp=%h", cyc, obs_d, e.val);
                    end
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL dout_cycle val=%h got_cyc=%0d exp_cyc=%0d", e.val, cyc,
                                 e.cyc);
                    end
                    seg_exp     = seg_of(e.val);
                    seg_pending = 1'b1;
                end
                prev_dout = obs_d;
            end
        end
    endtask

    task automatic drain(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing got=%0d_outstanding exp=0 next=%h@%0d", name, sb.size(),
                     sb[0].val, sb[0].cyc);
            sb.delete();
        end
    endtask

    task automatic restart();
        sel = 1'b0;
        @(negedge clk);
        mips_rst    = 1'b1;
        timer_rst   = 1'b1;
        segment_rst = 1'b1;
        @(negedge clk);
        mips_rst    = 1'b0;
        timer_rst   = 1'b0;
        segment_rst = 1'b0;
        cyc         = 0;
        prev_dout   = 8'h00;
        seg_pending = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got=%h exp=00", dout);
        end
        checks++;
        if (seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_segment got=%h exp=ff", seg);
        end
        segment_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (seg !== 8'hC0) begin
            errors++;
            $display("FAIL seg_release got=%h exp=c0", seg);
        end
        mips_rst = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL timer_held_dout got=%h exp=00", dout);
        end
    endtask

    task automatic test_count();
        din       = 32'd1;
        sel       = 1'b0;
        prev_dout = 8'h00;
        for (int n = 1; n <= 37; n++) push(8'(n), 16 * n + 3);
        timer_rst = 1'b0;
        cyc       = 0;
        run_sb(600);
        drain("count");
        checks++;
        if (dout !== 8'h25) begin
            errors++;
            $display("FAIL count_final got=%h exp=25", dout);
        end
        // Timer frozen: no further services, DOut and segment must hold.
        timer_rst = 1'b1;
        run_sb(50);
        checks++;
        if (dout !== 8'h25 || seg !== seg_of(8'h25)) begin
            errors++;
            $display("FAIL timer_freeze got=%h/%h exp=25/%h", dout, seg, seg_of(8'h25));
        end
    endtask

    task automatic test_byte_wrap();
        din = 32'h0000_00FF;
        restart();
        push(8'hFF, 19);
        push(8'hFE, 35);
        run_sb(40);
        drain("byte_wrap");
        checks++;
        if (dut.acc_q !== 32'h0000_01FE) begin
            errors++;
            $display("FAIL acc_1fe got=%h exp=000001fe", dut.acc_q);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] acc_exp;
        logic [7:0]  dout_exp;
`ifdef MINI_MACHINE_SATURATE_EN
        acc_exp  = 32'hFFFF_FFFF;
        dout_exp = 8'hFF;
`else
        acc_exp  = 32'h0000_0000;
        dout_exp = 8'h00;
`endif
        din = 32'd1;
        restart();
        push(8'h01, 19);
        run_sb(20);
        din = 32'hFFFF_FFFF;
        push(dout_exp, 35);
        run_sb(20);
        drain("overflow");
        checks++;
        if (dut.acc_q !== acc_exp) begin
            errors++;
            $display("FAIL acc_overflow got=%h exp=%h", dut.acc_q, acc_exp);
        end
    endtask

    task automatic test_mid_reset();
        din = 32'h0000_005A;
        restart();
        push(8'h5A, 19);
        // Second irq is sampled on edge 33, so the core sits in LOAD until edge 34.
        run_sb(33);
        mips_rst = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL midrst_dout got=%h exp=00", dout);
        end
        checks++;
        if (dut.acc_q !== 32'd0) begin
            errors++;
            $display("FAIL midrst_acc got=%h exp=00000000", dut.acc_q);
        end
        prev_dout   = 8'h00;
        seg_exp     = 8'hC0;
        seg_pending = 1'b1;
        run_sb(1);
        mips_rst = 1'b0;
        push(8'h5A, 51);
        run_sb(20);
        drain("mid_reset");
    endtask

    task automatic test_back_to_back();
        din4 = 32'd3;
        sel  = 1'b1;
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4        = 1'b0;
        cyc         = 0;
        prev_dout   = 8'h00;
        seg_pending = 1'b0;
        sb.delete();
        for (int n = 1; n <= 9; n++) push(8'(3 * n), 4 * n + 3);
        run_sb(40);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_count();
        test_byte_wrap();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
